fetch_ctrl: RTL
===============

# fetch_ctrl

Program-fetch sequencer for the 9-bit-instruction core. It owns the program counter that addresses the instruction ROM and latches the returned machine code into a one-entry fetch register for the decoder. It also handles program start/done handshaking, stalls, halts, and absolute/relative branches with a one-cycle squash. It sits between the top-level test harness (start/done), the instruction ROM (`prog_ctr` → `mach_code`) and the decode/execute stage.

## Interface
- `D`, 12, ROM address width; `prog_ctr` range is 0 .. 2^D−1.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `start`  in  1  begin a program; honoured only in IDLE or HALT.
- `start_addr`  in  D  first instruction address, captured with `start`.
- `stall`  in  1  hold PC and fetch register for this cycle.
- `branch_en`  in  1  branch for the instruction currently in `instr`.
- `branch_rel`  in  1  1 = target is `instr_pc + branch_off`; 0 = target is `branch_off`.
- `branch_off`  in  D  two's-complement offset (relative) or absolute address.
- `halt_req`  in  1  the instruction in `instr` is a halt.
- `mach_code`  in  9  combinational ROM data for `prog_ctr`.
- `prog_ctr`  out  D  ROM address (registered).
- `instr`  out  9  fetched instruction (registered).
- `instr_pc`  out  D  address `instr` was fetched from.
- `instr_valid`  out  1  `instr` is live for decode.
- `busy`  out  1  high in RUN.
- `done`  out  1  high in HALT.
- `err`  out  1  fetch overran top of ROM (see Configuration).

## Operation
- States: IDLE, RUN, HALT.
- Reset (`reset_n`=0 at an edge) puts the block in IDLE and clears all outputs to 0: `prog_ctr`, `instr`, `instr_pc`, `instr_valid`, `busy`, `done`, `err`. Reset takes effect from any state, including mid-RUN.
- IDLE or HALT with `start`=1 → RUN:
  - `prog_ctr` ← `start_addr`; `instr_valid` ← 0.
  - `done` ← 0; `err` ← 0; `busy` ← 1.
- In RUN, updates are evaluated in priority order each edge. Branch and halt inputs count only when `instr_valid`=1.
  1. `halt_req`: go to HALT; `instr_valid` ← 0; `busy` ← 0; `done` ← 1; `prog_ctr` is held.
  2. `stall`: all registers hold. The decoder must keep `branch_en`/`halt_req` stable through the stall.
  3. `branch_en`:
     - `prog_ctr` ← target. Relative target is `instr_pc + branch_off`; absolute target is `branch_off`; both are mod 2^D.
     - `instr_valid` ← 0, squashing the in-flight fetch.
  4. Otherwise:
     - `instr` ← `mach_code`; `instr_pc` ← `prog_ctr`; `instr_valid` ← 1.
     - `prog_ctr` ← `prog_ctr` + 1.
- `start` is ignored in RUN.
- `branch_en` and `halt_req` are ignored when `instr_valid`=0.
- In HALT, `prog_ctr`, `instr` and `instr_pc` hold their last values.

## Timing
- ROM is combinational, so fetch latency is 1 cycle: address in `prog_ctr` at edge N gives `instr` at edge N+1.
- Start sequence:
  - `start` sampled at edge 0.
  - Edge 1: `prog_ctr`=A, `busy`=1, `instr_valid`=0.
  - Edge 2: `instr`=core[A], `instr_pc`=A, `instr_valid`=1, `prog_ctr`=A+1.
- Steady state is one instruction per cycle without stalls.
- A taken branch costs 1 bubble cycle (`instr_valid`=0), then the target instruction arrives on the following edge.
- Halt: `done` rises one edge after `halt_req` is sampled. A new program may start on the next cycle.
- Top-of-ROM increment (`prog_ctr` = 2^D−1 with no branch) is governed by Configuration.

## Configuration
- Macro: `FETCH_WRAP_HALT_EN`.
- Defined: an increment from 2^D−1 does the following on the same edge:
  - loads `instr` = core[2^D−1] with `instr_valid` ← 0 (the overrun instruction is not issued);
  - enters HALT with `done` ← 1, `err` ← 1, `busy` ← 0;
  - holds `prog_ctr` at 2^D−1.
- Not defined:
  - `prog_ctr` wraps to 0 and RUN continues.
  - `err` is tied to 0.
- Branch targets always wrap mod 2^D regardless of the macro.

## Test plan
- Reset, then `start` with `start_addr`=0 on a ROM holding 9'h001, 9'h002, 9'h003 → `instr` sequence 001, 002, 003 on edges 2, 3, 4; `instr_pc` 0, 1, 2; `busy`=1.
- Relative branch at `instr_pc`=5 with `branch_off`=12'hFFD → one bubble cycle, then `instr_pc`=2. Absolute branch with `branch_off`=100 → `instr_pc`=100 after one bubble.
- Hold `stall` for 3 cycles with `branch_en`=1 → `prog_ctr` and `instr` frozen; the branch is taken on the first unstalled edge.
- `halt_req` and `branch_en` together at `instr_pc`=7 → HALT, `done`=1, `prog_ctr` held at 8. Then `start` with `start_addr`=20 → `instr_pc`=20 two edges later, `done`=0.
- `start_addr`=4094, D=12:
  - With `FETCH_WRAP_HALT_EN`: HALT with `err`=1 after `instr_pc`=4094.
  - Without it: `instr_pc` sequence 4094, 4095, 0.
- `reset_n`=0 for one edge mid-RUN → all outputs 0 and state IDLE on the next cycle. `start` is required to resume.

Source files
------------

// File: rtl/fetch_ctrl.sv
// Program-fetch sequencer: owns the ROM program counter and a one-entry fetch register.
// Optional FETCH_WRAP_HALT_EN: halt with err instead of wrapping when fetch runs past the top of ROM.
module fetch_ctrl #(
   parameter int D = 12
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         start,
   input  logic [D-1:0] start_addr,
   input  logic         stall,
   input  logic         branch_en,
   input  logic         branch_rel,
   input  logic [D-1:0] branch_off,
   input  logic         halt_req,
   input  logic [8:0]   mach_code,
   output logic [D-1:0] prog_ctr,
   output logic [8:0]   instr,
   output logic [D-1:0] instr_pc,
   output logic         instr_valid,
   output logic         busy,
   output logic         done,
   output logic         err
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT} state_t;

   state_t       state_q, state_d;
   logic [D-1:0] prog_ctr_q, prog_ctr_d;
   logic [8:0]   instr_q, instr_d;
   logic [D-1:0] instr_pc_q, instr_pc_d;
   logic         valid_q, valid_d;
   logic         busy_q, busy_d;
   logic         done_q, done_d;
   logic         err_q, err_d;
   logic [D-1:0] br_target;

   // Relative targets are taken from the address of the branching instruction, mod 2^D.
   assign br_target = branch_rel ? D'(instr_pc_q + branch_off) : branch_off;

   always_comb begin
      state_d    = state_q;
      prog_ctr_d = prog_ctr_q;
      instr_d    = instr_q;
      instr_pc_d = instr_pc_q;
      valid_d    = valid_q;
      busy_d     = busy_q;
      done_d     = done_q;
      err_d      = err_q;
      case (state_q)
         S_IDLE, S_HALT: begin
            if (start) begin
               state_d    = S_RUN;
               prog_ctr_d = start_addr;
               valid_d    = 1'b0;
               busy_d     = 1'b1;
               done_d     = 1'b0;
               err_d      = 1'b0;
            end
         end
         S_RUN: begin
            if (halt_req && valid_q) begin
               state_d = S_HALT;
               valid_d = 1'b0;
               busy_d  = 1'b0;
               done_d  = 1'b1;
            end else if (stall) begin
               state_d = S_RUN;
            end else if (branch_en && valid_q) begin
               // The word addressed this cycle is squashed; the target arrives after one bubble.
               prog_ctr_d = br_target;
               valid_d    = 1'b0;
            end else begin
`ifdef FETCH_WRAP_HALT_EN
               if (&prog_ctr_q) begin
                  instr_d = mach_code;
                  valid_d = 1'b0;
                  state_d = S_HALT;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  err_d   = 1'b1;
               end else begin
                  instr_d    = mach_code;
                  instr_pc_d = prog_ctr_q;
                  valid_d    = 1'b1;
                  prog_ctr_d = prog_ctr_q + D'(1);
               end
`else
               instr_d    = mach_code;
               instr_pc_d = prog_ctr_q;
               valid_d    = 1'b1;
               prog_ctr_d = prog_ctr_q + D'(1);
`endif
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q    <= S_IDLE;
         prog_ctr_q <= '0;
         instr_q    <= '0;
         instr_pc_q <= '0;
         valid_q    <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         prog_ctr_q <= prog_ctr_d;
         instr_q    <= instr_d;
         instr_pc_q <= instr_pc_d;
         valid_q    <= valid_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         err_q      <= err_d;
      end
   end

   assign prog_ctr    = prog_ctr_q;
   assign instr       = instr_q;
   assign instr_pc    = instr_pc_q;
   assign instr_valid = valid_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign err         = err_q;

endmodule
